// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared constants and types for the scoreboarded register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NREAD : default geometry
//   nreg()                              : register count for an address width
//   reg_addr_t / reg_data_t             : default-width address and data types
package regfile_sb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREAD  = 2;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    function automatic int nreg(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode-stage bus between issue/decode logic and regfile_sb.
//   master : drives read addresses, write-back and reserve requests
//   slave  : the register file, returns read data, busy flags and busy_vec
// Signals:
//   ra[NREAD*ADDR_W]  rd[NREAD*DATA_W]  rbusy[NREAD]
//   we, wa, wd        write-back port
//   res_en, res_a     reserve port
//   busy_vec[NREG]    registered busy bit per register
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREAD  = DEF_NREAD
) ();

    localparam int NREG = nreg(ADDR_W);

    logic [NREAD*ADDR_W-1:0] ra;
    logic [NREAD*DATA_W-1:0] rd;
    logic [NREAD-1:0]        rbusy;
    logic                    we;
    logic [ADDR_W-1:0]       wa;
    logic [DATA_W-1:0]       wd;
    logic                    res_en;
    logic [ADDR_W-1:0]       res_a;
    logic [NREG-1:0]         busy_vec;

    modport master (
        output ra, we, wa, wd, res_en, res_a,
        input  rd, rbusy, busy_vec
    );

    modport slave (
        input  ra, we, wa, wd, res_en, res_a,
        output rd, rbusy, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending bit per architectural register.
//   clk, reset        : clock, synchronous active-high clear
//   we, wa            : write-back clears busy[wa]
//   res_en, res_a     : reserve sets busy[res_a]
//   busy_vec[NREG]    : registered busy bits
// When ZERO_REG is nonzero, register 0 is never marked busy.
module rf_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic                    res_en,
    input  logic [ADDR_W-1:0]       res_a,
    output logic [nreg(ADDR_W)-1:0] busy_vec
);

    localparam int NREG    = nreg(ADDR_W);
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [NREG-1:0] busy_reg;
    logic            clr_ok;
    logic            set_ok;

    assign clr_ok = we     && !(ZERO_EN && (wa    == '0));
    assign set_ok = res_en && !(ZERO_EN && (res_a == '0));

    // The reserve update is issued after the clear so that, on a
    // same-address collision, the newer producer's reservation survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            if (clr_ok) begin
                busy_reg[wa] <= 1'b0;
            end
            if (set_ok) begin
                busy_reg[res_a] <= 1'b1;
            end
        end
    end

    assign busy_vec = busy_reg;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: NREAD-port register file with integrated scoreboard.
//   clk, reset : clock, synchronous active-high clear of data and busy bits
//   bus        : regfile_sb_if.slave (read ports, write-back, reserve, busy_vec)
// Reads are combinational from registered state. Optional macro
// REGFILE_SB_BYPASS_EN forwards a same-cycle write-back (wd, not busy) to any
// read port addressing the written register.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NREAD    = DEF_NREAD,
    parameter int ZERO_REG = 1
) (
    input logic        clk,
    input logic        reset,
    regfile_sb_if.slave bus
);

    localparam int NREG    = nreg(ADDR_W);
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_reg [NREG];
    logic [NREG-1:0]   busy;
    logic              wr_ok;

    wire [NREAD*DATA_W-1:0] rd_flat;
    wire [NREAD-1:0]        rbusy_flat;

    assign wr_ok = bus.we && !(ZERO_EN && (bus.wa == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_reg[bus.wa] <= bus.wd;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .we       (bus.we),
        .wa       (bus.wa),
        .res_en   (bus.res_en),
        .res_a    (bus.res_a),
        .busy_vec (busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_port
            logic [ADDR_W-1:0] addr;
            logic              zero;
            logic [DATA_W-1:0] port_rd;
            logic              port_busy;

            assign addr = bus.ra[gi*ADDR_W +: ADDR_W];
            assign zero = ZERO_EN && (addr == '0);

            always_comb begin
                port_rd   = mem_reg[addr];
                port_busy = busy[addr];
`ifdef REGFILE_SB_BYPASS_EN
                // A same-cycle reserve is not forwarded: it only shows up
                // in rbusy once it has been registered.
                if (bus.we && (bus.wa == addr)) begin
                    port_rd   = bus.wd;
                    port_busy = 1'b0;
                end
`endif
                if (zero) begin
                    port_rd   = '0;
                    port_busy = 1'b0;
                end
            end

            assign rd_flat[gi*DATA_W +: DATA_W] = port_rd;
            assign rbusy_flat[gi]               = port_busy;
        end
    endgenerate

    assign bus.rd       = rd_flat;
    assign bus.rbusy    = rbusy_flat;
    assign bus.busy_vec = busy;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with an integrated per-register scoreboard, the successor to the two-read/one-write MIPS register file. It sits in the decode stage of the pipelined core. It provides NREAD combinational read ports and one clocked write-back port, with optional same-cycle write-to-read bypass. A reserve port lets issue logic mark a destination register pending until its multicycle producer writes back, so decode can stall on `rbusy`.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; register count NREG = 2**ADDR_W
- `NREAD`, 2, number of read ports (1..8)
- `ZERO_REG`, 1, when 1 register 0 reads as 0 and ignores writes/reserves

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all registers and busy bits
- `ra`  in  NREAD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- `rd`  out  NREAD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- `rbusy`  out  NREAD  pending flag for each read address
- `we`  in  1  write-back enable
- `wa`  in  ADDR_W  write-back address
- `wd`  in  DATA_W  write-back data
- `res_en`  in  1  reserve enable: mark `res_a` pending
- `res_a`  in  ADDR_W  reserve address
- `busy_vec`  out  NREG  registered busy bit per register

## Operation
- Storage: NREG x DATA_W array plus NREG busy bits. All state is cleared only by `reset`.
- Read, per port i:
  - `rd[i]` = array[ra[i]]; `rbusy[i]` = busy[ra[i]].
  - With ZERO_REG=1 and ra[i]==0: `rd[i]`=0, `rbusy[i]`=0.
- Write: on a clock edge with `we`=1, array[wa] <= wd and busy[wa] <= 0.
- Reserve: on a clock edge with `res_en`=1, busy[res_a] <= 1.
- Simultaneous `we` and `res_en` to the same address: data is written and busy ends at 1. Reserve wins because it represents a newer producer.
- Simultaneous `we` and `res_en` to different addresses: both take effect independently.
- Reserving an already-busy register: busy stays 1. There is no counting; issue logic must not reserve a busy register.
- Writing a non-busy register is legal (single-cycle producers). Data is updated and busy stays 0.
- ZERO_REG=1: `we` or `res_en` to address 0 has no effect on any state.
- `reset`=1 at a clock edge:
  - all array entries and busy bits become 0;
  - `we` and `res_en` that cycle are ignored;
  - a reserved register mid-operation is cleared, and a late write-back after reset is an ordinary write.

## Timing
- Reads are combinational from `ra`, `we`, `wa`, `wd` (bypass only) and registered state. Zero-cycle latency.
- Write and reserve are visible on read ports in the cycle after the edge (one cycle), except via bypass.
- `busy_vec` is registered state. It is never bypassed.
- Reset values: array all 0, `busy_vec`=0. Consequently `rd`=0 and `rbusy`=0 for every address in the first cycle after reset.
- No handshake back-pressure: every `we`/`res_en` is accepted in the cycle presented.

## Configuration
- Macro `REGFILE_SB_BYPASS_EN`.
- Defined: for each port i where `we`=1, wa==ra[i] and the address is not a ZERO_REG zero:
  - `rd[i]`=wd;
  - `rbusy[i]`=0.
  - `res_en` in the same cycle does not affect `rbusy` until the next cycle.
- Not defined: read ports see only registered state, so a same-cycle write is visible next cycle. This replaces the old falling-edge-write scheme.

## Structure
- Package `regfile_sb_pkg`:
  - default DATA_W/ADDR_W/NREAD constants;
  - NREG localparam function;
  - typedefs for `reg_addr_t` and `reg_data_t`.
- Sub-module `rf_scoreboard`:
  - busy-bit array with reserve/write-back update and reset clear;
  - outputs `busy_vec`.
- Top level holds the data array, the read muxes and the bypass generate loop.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert `reset` one cycle → next cycle `rd`(ra=5)=0, `busy_vec`=0.
- Write latency: `we`=1, wa=7, wd=0x12345678 → same cycle `rd`(ra=7) equals the old value without macro and 0x12345678 with macro; the next cycle reads 0x12345678 in both builds.
- Zero register: `we` wa=0 wd=0xFFFFFFFF plus `res_en` res_a=0 → `rd`(ra=0)=0, `busy_vec[0]`=0.
- Scoreboard: `res_en` res_a=9 → next cycle `rbusy`=1 on all ports reading r9. `we` wa=9 wd=0xA5 → next cycle `rbusy`=0 and `rd`=0xA5.
- Collision: same cycle `we` wa=3 wd=0x55 and `res_en` res_a=3 → next cycle `rd`(ra=3)=0x55, `busy_vec[3]`=1.
- Reset mid-operation: reserve r12, assert `reset`, then `we` wa=12 wd=0x1 → `busy_vec[12]`=0 after reset; after the write, `rd`=0x1 and `rbusy`=0.
